// File: rtl/piso_serializer_if.sv
// Word-load handshake, bit strobe and framed serial output of the PISO transmitter.
// The producer/receiver side takes the master modport and the serializer takes the slave modport.
interface piso_serializer_if #(
  parameter int WIDTH = 4
) ();
  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic             d_ready;
  logic             en;
  logic             sout;
  logic             sout_valid;
  logic             sof;
  logic             eof;
  logic             busy;

  modport master (
    output d, d_valid, en,
    input  d_ready, sout, sout_valid, sof, eof, busy
  );

  modport slave (
    input  d, d_valid, en,
    output d_ready, sout, sout_valid, sof, eof, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// PISO transmitter: the first bit appears the cycle after a load, and each en=1 cycle consumes one bit.
// d_ready is high only when idle, or on the last bit when en=1, so back-to-back words give a gapless stream.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  piso_serializer_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             last_bit;
  logic             ready;
  logic             accept;
  logic [WIDTH-1:0] shifted;

  assign last_bit = (cnt_q == LAST);
  assign ready    = !rst && ((state_q == IDLE) || (state_q == SHIFT && last_bit && bus.en));
  assign accept   = bus.d_valid && ready;

  // The vacated end is zero-filled so the register drains cleanly between frames.
  assign shifted  = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                              : {1'b0, shreg_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = bus.d;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.en) begin
          if (!last_bit) begin
            shreg_d = shifted;
            cnt_d   = cnt_q + CW'(1);
          end else if (accept) begin
            shreg_d = bus.d;
            cnt_d   = '0;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.d_ready    = ready;
  assign bus.busy       = (state_q == SHIFT);
  assign bus.sout_valid = (state_q == SHIFT);
  assign bus.sout       = (state_q == SHIFT) &&
                          (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
  assign bus.sof        = (state_q == SHIFT) && (cnt_q == '0);
  assign bus.eof        = (state_q == SHIFT) && last_bit;

endmodule

// File: tb/tb_piso_serializer.sv
// Drives an MSB-first and an LSB-first serializer with identical stimulus and scores every cycle
// against a queue of expected frame bits.
module tb_piso_serializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] d = '0;
  logic         d_valid = 1'b0;
  logic         en = 1'b1;
  logic         en_toggle = 1'b0;
  logic         mon_on = 1'b0;

  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(W)) bus_m ();
  piso_serializer_if #(.WIDTH(W)) bus_l ();

  assign bus_m.d       = d;
  assign bus_m.d_valid = d_valid;
  assign bus_m.en      = en;
  assign bus_l.d       = d;
  assign bus_l.d_valid = d_valid;
  assign bus_l.en      = en;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk (clk),
    .rst (rst),
    .bus (bus_l)
  );

  typedef struct packed {
    logic [W-1:0] word;
    logic [1:0]   idx;
  } exp_bit_t;

  exp_bit_t sb_q[$];
  int       n_chk  = 0;
  int       n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Expected values for the cycle now showing, then the model advances across the next edge.
  exp_bit_t head;
  logic     m_rdy, e_v, e_sm, e_sl, e_sof, e_eof;

  always @(negedge clk) begin
    if (mon_on) begin
      m_rdy = !rst && (sb_q.size() == 0 || (sb_q.size() == 1 && en));
      e_v   = (sb_q.size() != 0);
      e_sm  = 1'b0;
      e_sl  = 1'b0;
      e_sof = 1'b0;
      e_eof = 1'b0;
      if (e_v) begin
        head  = sb_q[0];
        e_sm  = head.word[3 - head.idx];
        e_sl  = head.word[head.idx];
        e_sof = (head.idx == 2'd0);
        e_eof = (head.idx == 2'd3);
      end
      check_eq("msb_ready", bus_m.d_ready,    m_rdy);
      check_eq("msb_valid", bus_m.sout_valid, e_v);
      check_eq("msb_busy",  bus_m.busy,       e_v);
      check_eq("msb_sout",  bus_m.sout,       e_sm);
      check_eq("msb_sof",   bus_m.sof,        e_sof);
      check_eq("msb_eof",   bus_m.eof,        e_eof);
      check_eq("lsb_ready", bus_l.d_ready,    m_rdy);
      check_eq("lsb_valid", bus_l.sout_valid, e_v);
      check_eq("lsb_busy",  bus_l.busy,       e_v);
      check_eq("lsb_sout",  bus_l.sout,       e_sl);
      check_eq("lsb_sof",   bus_l.sof,        e_sof);
      check_eq("lsb_eof",   bus_l.eof,        e_eof);
      if (rst) begin
        sb_q.delete();
      end else begin
        if (en && sb_q.size() != 0) void'(sb_q.pop_front());
        if (d_valid && m_rdy)
          for (int i = 0; i < W; i++) sb_q.push_back('{word: d, idx: 2'(i)});
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      en = en_toggle ? ~en : 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] w);
    logic ok;
    int   t;
    ok = 1'b0;
    t  = 0;
    d       = w;
    d_valid = 1'b1;
    while (!ok && t < 50) begin
      @(negedge clk);
      ok = bus_m.d_ready;
      tick();
      t++;
    end
    d_valid = 1'b0;
    check_eq("accept", ok, 1'b1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 100) begin
      tick();
      t++;
    end
    check_eq("drain", sb_q.size(), 0);
    tick();
    tick();
  endtask

  initial begin
    // Reset held with a pending word: nothing may load.
    rst     = 1'b1;
    d       = 4'b1111;
    d_valid = 1'b1;
    tick();
    mon_on = 1'b1;
    tick();
    rst     = 1'b0;
    d_valid = 1'b0;
    tick();
    tick();

    send(4'b1000);
    wait_idle();

    en_toggle = 1'b1;
    send(4'b1011);
    wait_idle();
    en_toggle = 1'b0;
    tick();

    send(4'b1010);
    send(4'b0110);
    wait_idle();

    send(4'b0011);
    wait_idle();

    // Abort after two bits of 1100 are consumed, then a clean frame.
    send(4'b1100);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send(4'b0001);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out transmitter: the send side of the 4-bit shift-register link. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per enabled cycle, with frame markers. Bit pacing comes from an external strobe, so the serial rate matches whatever drives the receiving shift register's enable.

## Interface
- WIDTH, 4, word length in bits; legal range is 2 or more
- MSB_FIRST, 1, 1 sends d[WIDTH-1] first; 0 sends d[0] first

- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- d  in  WIDTH  parallel word to transmit
- d_valid  in  1  d holds a word to load
- d_ready  out  1  serializer accepts d this cycle
- en  in  1  bit strobe; the current bit is consumed on a cycle where en=1
- sout  out  1  serial data bit
- sout_valid  out  1  sout carries a frame bit
- sof  out  1  current bit is the first of its frame
- eof  out  1  current bit is the last of its frame
- busy  out  1  a frame is in progress

## Operation
- State machine with two states:
  - IDLE: no frame in progress.
  - SHIFT: a frame is in progress. It holds a WIDTH-bit shift register `shreg` and a bit counter `cnt`, 0..WIDTH-1, sized ceil(log2(WIDTH)).
- Load accept: `accept` = d_valid && d_ready.
- d_ready is combinational: !rst && (state==IDLE || (state==SHIFT && cnt==WIDTH-1 && en)).
- In IDLE:
  - On accept: shreg<=d, cnt<=0, go to SHIFT.
  - Otherwise stay in IDLE.
- In SHIFT with en=1 and cnt<WIDTH-1:
  - Shift shreg toward the output end. It moves left when MSB_FIRST=1 and right when MSB_FIRST=0; the vacated bit is filled with 0.
  - cnt<=cnt+1.
- In SHIFT with en=1 and cnt==WIDTH-1:
  - On accept (back-to-back): shreg<=d, cnt<=0, stay in SHIFT.
  - Otherwise go to IDLE and clear cnt.
- In SHIFT with en=0: shreg, cnt and all outputs hold.
- Outputs:
  - sout = shreg[WIDTH-1] when MSB_FIRST=1, else shreg[0]. sout is forced to 0 in IDLE.
  - sout_valid = busy = (state==SHIFT).
  - sof = sout_valid && cnt==0.
  - eof = sout_valid && cnt==WIDTH-1.
- d_valid while d_ready=0 is ignored. The producer holds d and d_valid until it sees d_ready.
- The receiver samples sout on cycles where sout_valid && en.

## Timing
- While rst=1 at a clock edge:
  - state<=IDLE, shreg<=0, cnt<=0.
  - After the edge: sout=0, sout_valid=0, sof=0, eof=0, busy=0.
  - d_ready=0 for as long as rst=1, so no load can occur during reset.
- Load latency: on an accept at edge k, the first bit appears on sout with sof=1 in the cycle after edge k.
- With en held at 1, a frame takes exactly WIDTH cycles and eof is set in its last cycle.
- Each cycle with en=0 stretches the current bit by one cycle.
- Back-to-back loads produce a gapless stream:
  - d_ready rises in the eof cycle when en=1.
  - The first bit of the next frame follows with no idle cycle.
- Reset mid-frame:
  - The partial word is discarded and no further frame bits are emitted.
  - The block is in IDLE on the cycle after the reset edge.
  - d_ready=1 as soon as rst falls.
- Simultaneous rst and accept: rst wins, and the word is not loaded.

## Test plan
- Reset: rst=1 for 2 cycles with d_valid=1, d=4'b1111 -> sout_valid, busy, sof and eof all 0, d_ready=0, no load afterwards.
- MSB-first frame: WIDTH=4, MSB_FIRST=1, load 4'b1000, en=1 continuously -> sout=1,0,0,0 on four consecutive cycles, sof only on the first, eof only on the fourth; the next cycle has sout_valid=0 and d_ready=1.
- Paced frame: en toggling 1,0,1,0,..., load 4'b1011 -> each bit held 2 cycles, sequence 1,0,1,1 over 8 cycles, sof and eof each held for 2 cycles.
- Back-to-back: load 4'b1010, with 4'b0110 presented on d_valid during the first frame, en=1 -> d_ready=1 only in the eof cycle; 8 contiguous valid bits 1,0,1,0,0,1,1,0 with no gap; sof in cycles 1 and 5.
- LSB-first frame: MSB_FIRST=0, load 4'b1000 -> sout=0,0,0,1.
- Abort: assert rst for 1 cycle after the 2nd bit of 4'b1100 -> sout_valid=0 on the following cycle; after rst falls, load 4'b0001 -> sout=0,0,0,1 with sof set on its first bit.
